// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer queue and its bench.
package spi_pkg;
    localparam int SPI_BYTE_W     = 8;
    localparam int XQ_DEPTH       = 8;
    localparam int XQ_TIMEOUT_CYC = 128;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } xq_state_e;
endpackage

// File: rtl/spi_byte_fifo.sv
// First-word-fall-through FIFO with occupancy count; DEPTH must be a power of two.
module spi_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Requests against a full/empty FIFO are dropped here so callers can pass raw valid/ready.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Head reads as zero when empty so the port has a defined idle value.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally at the power-of-two boundary; count tracks net push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; only entries below count are ever visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/spi_xfer_queue.sv
// Byte queue in front of an SPI master: TX FIFO -> one transfer per byte -> RX FIFO,
// with a watchdog that abandons transfers whose done never comes back.
module spi_xfer_queue
    import spi_pkg::*;
#(
    parameter int DEPTH       = XQ_DEPTH,
    parameter int TIMEOUT_CYC = XQ_TIMEOUT_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SPI_BYTE_W-1:0]  tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [SPI_BYTE_W-1:0]  rx_data,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic                   spi_start,
    output logic [SPI_BYTE_W-1:0]  spi_data_in,
    input  logic [SPI_BYTE_W-1:0]  spi_data_out,
    input  logic                   spi_done,
    input  logic                   err_clr,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [$clog2(DEPTH):0] tx_count,
    output logic [$clog2(DEPTH):0] rx_count
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    xq_state_e             state, state_nx;
    logic [WD_W-1:0]       wd;
    logic                  tx_pop, rx_push, to_hit;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [SPI_BYTE_W-1:0] tx_head;

    assign tx_ready = !tx_full;
    assign rx_valid = !rx_empty;

    spi_byte_fifo #(.DEPTH(DEPTH), .W(SPI_BYTE_W)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_valid), .pop(tx_pop), .wdata(tx_data),
        .rdata(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    // A done coinciding with reset must not land in the RX FIFO.
    spi_byte_fifo #(.DEPTH(DEPTH), .W(SPI_BYTE_W)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push && !rst), .pop(rx_ready), .wdata(spi_data_out),
        .rdata(rx_data), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // Sequencer next-state: launch only with RX space reserved, since we are the sole RX writer.
    always_comb begin
        state_nx = state;
        tx_pop   = 1'b0;
        rx_push  = 1'b0;
        to_hit   = 1'b0;
        case (state)
            IDLE:      if (!tx_empty && !rx_full) state_nx = LAUNCH;
            LAUNCH: begin
                tx_pop   = 1'b1;
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (spi_done) begin
                    rx_push  = 1'b1;
                    state_nx = GAP;
                end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
                    to_hit   = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // State, registered command outputs and watchdog; start pulses the cycle after LAUNCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            spi_start   <= 1'b0;
            spi_data_in <= '0;
            busy        <= 1'b0;
            wd          <= '0;
        end else begin
            state     <= state_nx;
            spi_start <= (state == LAUNCH);
            if (state == LAUNCH) spi_data_in <= tx_head;
            busy      <= (state_nx != IDLE);
            wd        <= (state == WAIT_DONE) ? wd + WD_W'(1) : '0;
        end
    end

    // Sticky timeout flag; a new timeout wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)          timeout_err <= 1'b0;
        else if (to_hit)  timeout_err <= 1'b1;
        else if (err_clr) timeout_err <= 1'b0;
    end
endmodule

// File: tb/tb_spi_xfer_queue.sv
// Directed bench for spi_xfer_queue with a behavioural SPI master model.
module tb_spi_xfer_queue;
    import spi_pkg::*;

    logic       clk, rst;
    logic [7:0] tx_data, rx_data, spi_data_in, spi_data_out;
    logic       tx_valid, tx_ready, rx_valid, rx_ready;
    logic       spi_start, spi_done, spi_done_m, stray_done;
    logic       err_clr, busy, timeout_err;
    logic [$clog2(XQ_DEPTH):0] tx_count, rx_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // master model state
    bit         m_en = 1'b1;
    int         m_lat = 20;
    logic [7:0] m_key = 8'h99;
    int         m_cnt = 0;
    logic [7:0] m_resp = 8'h00;
    int         start_cnt = 0;
    int         last_start = -100;
    int         gap_bad = 0;
    logic [7:0] launched[$];
    logic [7:0] rx_q[$];
    bit         saw_full;
    int         base;

    assign spi_done = spi_done_m | stray_done;

    spi_xfer_queue #(.DEPTH(XQ_DEPTH), .TIMEOUT_CYC(XQ_TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .spi_start(spi_start), .spi_data_in(spi_data_in),
        .spi_data_out(spi_data_out), .spi_done(spi_done),
        .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // SPI master: log each start, answer with data_in ^ key after m_lat cycles.
    initial begin
        spi_done_m   = 1'b0;
        spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            spi_done_m = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    spi_done_m   = 1'b1;
                    spi_data_out = m_resp;
                end
            end
            if (spi_start === 1'b1) begin
                start_cnt++;
                launched.push_back(spi_data_in);
                if (cyc - last_start < 4) gap_bad++;
                last_start = cyc;
                if (m_en) begin
                    m_cnt  = m_lat;
                    m_resp = spi_data_in ^ m_key;
                end
            end
        end
    end

    // Host RX side: record every byte that will be popped at the next edge.
    always @(negedge clk) if (rx_valid === 1'b1 && rx_ready === 1'b1) rx_q.push_back(rx_data);

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string p);
        chk({p, "_start"}, 32'(spi_start), 0);
        chk({p, "_data_in"}, 32'(spi_data_in), 0);
        chk({p, "_tx_ready"}, 32'(tx_ready), 1);
        chk({p, "_rx_valid"}, 32'(rx_valid), 0);
        chk({p, "_rx_data"}, 32'(rx_data), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_err"}, 32'(timeout_err), 0);
        chk({p, "_tx_count"}, 32'(tx_count), 0);
        chk({p, "_rx_count"}, 32'(rx_count), 0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int c = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && c < 500) begin
            if (!saw_full) chk("txfull_count", 32'(tx_count), XQ_DEPTH);
            saw_full = 1'b1;
            tick(1);
            c++;
        end
        chk("push_bound", 32'(c < 500), 1);
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        chk("rx_drain_size", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic clear_logs();
        launched.delete();
        rx_q.delete();
        base = start_cnt;
    endtask

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        err_clr = 1'b0; stray_done = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset("rst0");

        // single byte: A5 out, 3C back after 20 cycles
        clear_logs();
        tx_data = 8'hA5; tx_valid = 1'b1;
        tick(1);                                   // cycle 0
        tx_valid = 1'b0;
        chk("single_tx_count", 32'(tx_count), 1);
        tick(1);                                   // cycle 1
        chk("single_start_c1", 32'(spi_start), 0);
        chk("single_busy_c1", 32'(busy), 1);
        tick(1);                                   // cycle 2
        chk("single_start_c2", 32'(spi_start), 1);
        chk("single_data_in", 32'(spi_data_in), 32'h A5);
        tick(20);                                  // cycle 22: done high
        chk("single_rxv_c22", 32'(rx_valid), 0);
        tick(1);                                   // cycle 23
        chk("single_rxv_c23", 32'(rx_valid), 1);
        chk("single_rx_data", 32'(rx_data), 32'h3C);
        chk("single_rx_count", 32'(rx_count), 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("single_rxv_pop", 32'(rx_valid), 0);
        chk("single_starts", 32'(start_cnt - base), 1);
        chk("single_rx_q", 32'(rx_q.size() > 0 ? rx_q[0] : 8'hxx), 32'h3C);

        // burst with backpressure: 10 bytes through an 8-deep TX FIFO
        clear_logs();
        m_lat = 30; m_key = 8'h55; saw_full = 1'b0; rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'(i));
        chk("burst_saw_full", 32'(saw_full), 1);
        wait_rx(10, 1000);
        chk("burst_starts", 32'(start_cnt - base), 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("burst_tx%0d", i), 32'(i < launched.size() ? launched[i] : 8'hxx), 32'(i));
            chk($sformatf("burst_rx%0d", i), 32'(i < rx_q.size() ? rx_q[i] : 8'hxx), 32'(i ^ 8'h55));
        end
        rx_ready = 1'b0;

        // RX full stalls the 9th launch until the host pops one
        clear_logs();
        m_lat = 2;
        for (int i = 0; i < 9; i++) push_byte(8'h20 + 8'(i));
        tick(200);
        chk("rxfull_count", 32'(rx_count), 8);
        chk("rxfull_starts", 32'(start_cnt - base), 8);
        chk("rxfull_tx_count", 32'(tx_count), 1);
        chk("rxfull_busy", 32'(busy), 0);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(20);
        chk("rxfull_starts9", 32'(start_cnt - base), 9);
        chk("rxfull_count2", 32'(rx_count), 8);
        rx_ready = 1'b1;
        wait_rx(9, 200);
        for (int i = 0; i < 9; i++)
            chk($sformatf("rxfull_rx%0d", i), 32'(i < rx_q.size() ? rx_q[i] : 8'hxx),
                32'((8'h20 + i) ^ 8'h55));
        rx_ready = 1'b0;

        // timeout: master silent
        clear_logs();
        m_en = 1'b0;
        tx_data = 8'h11; tx_valid = 1'b1;
        tick(1);                                   // cycle 0
        tx_data = 8'h22;
        tick(1);                                   // cycle 1
        tx_valid = 1'b0;
        tick(128);                                 // cycle 129
        chk("to_err_c129", 32'(timeout_err), 0);
        tick(1);                                   // cycle 130
        chk("to_err_c130", 32'(timeout_err), 1);
        chk("to_rx_count", 32'(rx_count), 0);
        tick(3);                                   // cycle 133
        chk("to_next_start", 32'(spi_start), 1);
        chk("to_next_data", 32'(spi_data_in), 32'h22);
        tick(1);                                   // cycle 134
        err_clr = 1'b1;
        tick(1);                                   // cycle 135
        err_clr = 1'b0;
        chk("to_err_cleared", 32'(timeout_err), 0);
        tick(125);                                 // cycle 260: second timeout fires
        chk("to_err_c260", 32'(timeout_err), 0);
        err_clr = 1'b1;
        tick(1);                                   // cycle 261
        err_clr = 1'b0;
        chk("to_set_wins", 32'(timeout_err), 1);
        tick(1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("to_err_clr2", 32'(timeout_err), 0);
        chk("to_rx_valid", 32'(rx_valid), 0);
        chk("to_busy", 32'(busy), 0);

        // stray done in IDLE
        clear_logs();
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        tick(3);
        chk("stray_rx_count", 32'(rx_count), 0);
        chk("stray_busy", 32'(busy), 0);

        // reset in WAIT_DONE with a coinciding done
        tx_data = 8'h33; tx_valid = 1'b1;
        tick(1);                                   // cycle 0
        tx_data = 8'h44;
        tick(1);                                   // cycle 1
        tx_valid = 1'b0;
        tick(4);                                   // cycle 5
        chk("mid_busy", 32'(busy), 1);
        chk("mid_tx_count", 32'(tx_count), 1);
        rst = 1'b1; stray_done = 1'b1;
        tick(1);
        rst = 1'b0; stray_done = 1'b0;
        check_reset("mid");
        tick(5);
        chk("mid_no_relaunch", 32'(start_cnt - base), 1);
        chk("mid_rx_count", 32'(rx_count), 0);

        // wrap: 20 bytes streamed with fast master
        clear_logs();
        m_en = 1'b1; m_lat = 1; m_key = 8'h5A; rx_ready = 1'b1; gap_bad = 0;
        for (int i = 0; i < 20; i++) push_byte(8'h80 + 8'(i));
        wait_rx(20, 1000);
        chk("wrap_starts", 32'(start_cnt - base), 20);
        chk("wrap_gap", 32'(gap_bad), 0);
        for (int i = 0; i < 20; i++)
            chk($sformatf("wrap_rx%0d", i), 32'(i < rx_q.size() ? rx_q[i] : 8'hxx),
                32'((8'h80 + i) ^ 8'h5A));
        rx_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_xfer_queue.md
# spi_xfer_queue

Byte-stream front end that sits directly upstream of the SPI master and drives its `start`/`data_in` command side while consuming its `data_out`/`done` result side. Host bytes enter a TX FIFO through a valid/ready port. A sequencer launches one SPI transfer per byte and waits for `done`. Each received byte is pushed into an RX FIFO and returned to the host through a second valid/ready port. A watchdog flags transfers whose `done` never arrives.

## Interface
- `DEPTH`, 8: entries per FIFO; power of two, ≥2.
- `TIMEOUT_CYC`, 128: clk cycles in WAIT_DONE before a transfer is abandoned; ≥2.

Ports:
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `rst` in 1: synchronous, active-high reset, shared with the SPI master.
- `tx_data` in 8: host byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: TX FIFO can accept a byte.
- `rx_data` out 8: received byte at the RX FIFO head.
- `rx_valid` out 1: RX FIFO is non-empty.
- `rx_ready` in 1: host consumes the `rx_data` byte.
- `spi_start` out 1: one-cycle launch pulse to the SPI master.
- `spi_data_in` out 8: byte to shift out on mosi.
- `spi_data_out` in 8: byte shifted in on miso.
- `spi_done` in 1: transfer-complete pulse from the SPI master.
- `err_clr` in 1: clears `timeout_err`.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: sticky watchdog flag.
- `tx_count`, `rx_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FSM states are IDLE, LAUNCH, WAIT_DONE, GAP.
- **IDLE → LAUNCH** when TX is non-empty and RX is not full. The RX space reserved here is guaranteed at capture, because only this block pushes RX.
- **LAUNCH** (one cycle):
  - `spi_start`=1.
  - `spi_data_in` is loaded from the TX head and held stable until the next LAUNCH.
  - TX is popped.
  - Always → WAIT_DONE.
- **WAIT_DONE**:
  - On `spi_done`=1: push `spi_data_out` into RX and go to GAP.
  - Otherwise the watchdog increments. When it reaches `TIMEOUT_CYC`-1 with no `spi_done`: set `timeout_err`, push nothing, go to GAP. That byte is lost.
- **GAP** (one cycle): always → IDLE. This gives the SPI master one cycle to deassert ss after `done`, so back-to-back `start` never overlaps an active frame.
- `spi_done` seen in any state other than WAIT_DONE is ignored.
- Watchdog clears on entry to WAIT_DONE.
- `timeout_err`:
  - Set has priority over `err_clr` in the same cycle.
  - Otherwise `err_clr`=1 clears it.
- FIFOs:
  - Push occurs on `tx_valid && tx_ready`; pop occurs on `rx_valid && rx_ready`.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo `DEPTH`.
  - `tx_ready` = !tx_full, purely from occupancy. A same-cycle pop does not open a full FIFO.
  - `rx_data` is first-word-fall-through (head is visible while `rx_valid`).

## Timing
- Reset values:
  - `spi_start`=0, `spi_data_in`=0.
  - `tx_ready`=1, `rx_valid`=0, `rx_data`=0.
  - `busy`=0, `timeout_err`=0, `tx_count`=`rx_count`=0.
  - State IDLE, both FIFOs empty.
- Reset mid-transfer:
  - Abandons the transfer and flushes both FIFOs.
  - No RX push occurs, even if `spi_done` coincides with `rst`.
- `spi_start`, `spi_data_in`, `busy`, and flags are registered outputs.
- Latency, empty queue, byte accepted at edge 0:
  - LAUNCH (`spi_start`=1) is cycle 2.
  - If `spi_done` is high in cycle k, `rx_valid`=1 from cycle k+1.
  - The next LAUNCH is no earlier than cycle k+3.
- Minimum per-byte period is 4 cycles plus the SPI master's transfer time.
- `tx_count`/`rx_count` reflect the push/pop from the previous edge.

## Structure
- Shared package `spi_pkg` holds:
  - `xq_state_e` (IDLE, LAUNCH, WAIT_DONE, GAP).
  - `SPI_BYTE_W`=8.
  - Default `DEPTH`/`TIMEOUT_CYC` constants, also used by the bench.
- One sub-module, `spi_byte_fifo`: parameterized `DEPTH` and width, FWFT, with count/full/empty. It is instantiated twice (TX, RX).
- The FSM, watchdog, and error flag live in the top module.

## Test plan
- **Single byte:** push 8'hA5; model master returns 8'h3C with `done` 20 cycles after `start`. Required: exactly one `spi_start` pulse with `spi_data_in`=8'hA5; `rx_data`=8'h3C with `rx_valid` one cycle after `done`.
- **Burst/backpressure:** push 10 bytes 8'h00..8'h09 with `DEPTH`=8. Required: `tx_ready` falls when `tx_count`=8; all 10 are launched in order; `start` pulses are ≥4 cycles apart; RX order matches.
- **RX full:** hold `rx_ready`=0 and push 9 bytes. Required: 8 transfers complete, `rx_count`=8, no 9th `spi_start`. Pop one → the 9th launches.
- **Timeout:** never assert `done`. Required:
  - `timeout_err`=1 after `TIMEOUT_CYC` cycles in WAIT_DONE; no RX push; next byte launches.
  - `err_clr` clears the flag.
  - `err_clr` coinciding with a second timeout leaves it set.
- **Stray/reset:** pulse `spi_done` in IDLE → no RX push. Assert `rst` in WAIT_DONE together with `spi_done` → all outputs return to reset values and `rx_count`=0.
- **Wrap:** stream 20 bytes with `rx_ready`=1. Required: pointers wrap cleanly and all 20 echoes are in order with no loss.
